mm_sequencer: RTL and testbench

MM_SEQUENCER -- requirements
Module: mm_sequencer

---
 rtl/mm_sequencer.sv | 156 +++++++++++++++
 tb/tb_mm_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_sequencer.sv
// mm_sequencer: operand/result sequencer for an N x N systolic array.
//   Loads N A-rows then N W-rows over a valid/ready stream, starts the
//   array, feeds diagonally skewed operand lanes for 2N-1 beats, waits
//   (bounded by TIMEOUT) for the array to finish, captures N result rows
//   and streams them out with a last marker.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ld_valid/ld_ready/ld_data   operand load stream, one 8N-bit row per beat
//   arr_start                   one-cycle start pulse to the array
//   arr_ready, arr_done         array idle level / completion pulse
//   arr_a, arr_w                skewed operand lanes (8 bits per lane)
//   arr_y                       result row from the array
//   res_valid/res_ready/res_data/res_last  result stream
//   busy, err                   not-idle status / sticky timeout flag
module mm_sequencer #(
    parameter int unsigned N       = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [8*N-1:0]   ld_data,
    output logic             arr_start,
    input  logic             arr_ready,
    input  logic             arr_done,
    output logic [8*N-1:0]   arr_a,
    output logic [8*N-1:0]   arr_w,
    input  logic [8*N-1:0]   arr_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [8*N-1:0]   res_data,
    output logic             res_last,
    output logic             busy,
    output logic             err
);

    localparam int unsigned LW = $clog2(2 * N);
    localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, ISSUE, FEED, WAIT, CAPTURE, DRAIN
    } state_t;

    state_t state, state_next;

    logic [LW-1:0] ld_cnt;
    logic [LW-1:0] feed_cnt;
    logic [TW-1:0] wait_cnt;
    logic [RW-1:0] cap_cnt;
    logic [RW-1:0] row_idx;
    logic [RW-1:0] ld_row;

    logic [7:0]     a_mem [N][N];
    logic [7:0]     w_mem [N][N];
    logic [8*N-1:0] y_mem [N];

    logic ld_fire, ld_last, feed_last, wait_expire, cap_last, res_fire, row_last;

    always_comb begin
        ld_ready    = (state == IDLE) || (state == LOAD);
        ld_fire     = ld_valid && ld_ready;
        ld_last     = (ld_cnt == LW'(2 * N - 1));
        ld_row      = (ld_cnt < LW'(N)) ? RW'(ld_cnt) : RW'(ld_cnt - LW'(N));
        feed_last   = (feed_cnt == LW'(2 * N - 2));
        wait_expire = (wait_cnt == TW'(TIMEOUT - 1));
        cap_last    = (cap_cnt == RW'(N - 1));
        res_valid   = (state == DRAIN);
        row_last    = (row_idx == RW'(N - 1));
        res_fire    = res_valid && res_ready;
        res_last    = res_valid && row_last;
        res_data    = res_valid ? y_mem[row_idx] : '0;
        arr_start   = (state == ISSUE) && arr_ready;
        busy        = (state != IDLE);
    end

    // Lane i sees element (t - i) of its row/column, zero outside the diagonal band.
    always_comb begin
        arr_a = '0;
        arr_w = '0;
        if (state == FEED) begin
            for (int unsigned i = 0; i < N; i++) begin
                if ((32'(feed_cnt) >= i) && (32'(feed_cnt) - i < N)) begin
                    arr_a[8*i +: 8] = a_mem[RW'(i)][RW'(32'(feed_cnt) - i)];
                    arr_w[8*i +: 8] = w_mem[RW'(32'(feed_cnt) - i)][RW'(i)];
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ld_fire) state_next = ld_last ? ISSUE : LOAD;
            LOAD:    if (ld_fire && ld_last) state_next = ISSUE;
            ISSUE:   if (arr_ready) state_next = FEED;
            FEED:    if (feed_last) state_next = WAIT;
            // done is tested before expiry so a done on the final WAIT cycle wins
            WAIT: begin
                if (arr_done)         state_next = (N == 1) ? DRAIN : CAPTURE;
                else if (wait_expire) state_next = IDLE;
            end
            CAPTURE: if (cap_last) state_next = DRAIN;
            DRAIN:   if (res_fire && row_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_cnt   <= '0;
            feed_cnt <= '0;
            wait_cnt <= '0;
            cap_cnt  <= '0;
            row_idx  <= '0;
            err      <= 1'b0;
        end else begin
            if (ld_fire)
                ld_cnt <= ld_last ? '0 : ld_cnt + LW'(1);
            if (state == FEED)
                feed_cnt <= feed_last ? '0 : feed_cnt + LW'(1);
            wait_cnt <= (state == WAIT) ? wait_cnt + TW'(1) : '0;
            if (state == WAIT && arr_done)
                cap_cnt <= RW'(1);
            else if (state == CAPTURE)
                cap_cnt <= cap_cnt + RW'(1);
            if (res_fire)
                row_idx <= row_last ? '0 : row_idx + RW'(1);
            if (state == WAIT && !arr_done && wait_expire)
                err <= 1'b1;
            else if (ld_fire)
                err <= 1'b0;
        end
    end

    // Operand and result storage is never reset; validity is tracked by the FSM.
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (ld_cnt < LW'(N)) a_mem[ld_row][RW'(k)] <= ld_data[8*k +: 8];
                else                 w_mem[ld_row][RW'(k)] <= ld_data[8*k +: 8];
            end
        end
        if (state == WAIT && arr_done)
            y_mem[0] <= arr_y;
        else if (state == CAPTURE)
            y_mem[cap_cnt] <= arr_y;
    end

endmodule

// File: tb/tb_mm_sequencer.sv
// tb_mm_sequencer: self-checking bench for mm_sequencer with a behavioural
// array model, randomized operands/results, handshake gaps and backpressure.
module tb_mm_sequencer;

    localparam int N  = 4;
    localparam int TO = 16;
    localparam int WD = 8 * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid;
    logic          ld_ready;
    logic [WD-1:0] ld_data;
    logic          arr_start;
    logic          arr_ready;
    logic          arr_done;
    logic [WD-1:0] arr_a;
    logic [WD-1:0] arr_w;
    logic [WD-1:0] arr_y;
    logic          res_valid;
    logic          res_ready;
    logic [WD-1:0] res_data;
    logic          res_last;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    mm_sequencer #(.N(N), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .arr_start (arr_start),
        .arr_ready (arr_ready),
        .arr_done  (arr_done),
        .arr_a     (arr_a),
        .arr_w     (arr_w),
        .arr_y     (arr_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_last  (res_last),
        .busy      (busy),
        .err       (err)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]    ma [N][N];
    logic [7:0]    mw [N][N];
    logic [WD-1:0] my [N];
    logic          model_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WD-1:0] pack_a(input int r);
        logic [WD-1:0] v;
        for (int k = 0; k < N; k++) v[8*k +: 8] = ma[r][k];
        return v;
    endfunction

    function automatic logic [WD-1:0] pack_w(input int r);
        logic [WD-1:0] v;
        for (int k = 0; k < N; k++) v[8*k +: 8] = mw[r][k];
        return v;
    endfunction

    // Diagonal schedule: on beat t, lane i carries A[i][t-i] and W[t-i][i].
    function automatic logic [WD-1:0] skew_a(input int t);
        logic [WD-1:0] v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[8*i +: 8] = ma[i][t-i];
        return v;
    endfunction

    function automatic logic [WD-1:0] skew_w(input int t);
        logic [WD-1:0] v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[8*j +: 8] = mw[t-j][j];
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // done_delay < 0: the array never completes.
    task automatic run_job(input bit basic, input int start_delay, input int done_delay,
                           input int bp_row, input int bp_len, input bit mid_rst,
                           input bit noise);
        int b;
        int r;
        int held;
        int cyc;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                ma[i][k] = basic ? 8'(i * N + k + 1) : 8'($urandom);
                mw[i][k] = basic ? 8'(i == k) : 8'($urandom);
            end
        end
        for (int i = 0; i < N; i++)
            my[i] = basic ? pack_a(i) : WD'({$urandom, $urandom});

        b = 0;
        while (b < 2 * N) begin
            ld_valid = basic || ($urandom % 4 != 0);
            ld_data  = (b < N) ? pack_a(b) : pack_w(b - N);
            @(negedge clk);
            check("ld_ready_load", ld_ready, 1);
            check("err_load", err, model_err);
            check("busy_load", busy, b != 0);
            next_cycle();
            if (ld_valid) begin
                b++;
                model_err = 1'b0;
            end
        end
        ld_valid = 1'b0;
        ld_data  = WD'($urandom);

        for (int i = 0; i < start_delay; i++) begin
            arr_ready = 1'b0;
            arr_done  = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
            check("start_held", arr_start, 0);
            check("ld_ready_issue", ld_ready, 0);
            check("busy_issue", busy, 1);
            next_cycle();
        end
        arr_ready = 1'b1;
        @(negedge clk);
        check("start_pulse", arr_start, 1);
        next_cycle();

        for (int t = 0; t < 2 * N - 1; t++) begin
            arr_ready = noise ? 1'($urandom) : 1'b1;
            arr_done  = noise ? 1'($urandom) : 1'b0;
            if (mid_rst && t == 2) rst = 1'b1;
            @(negedge clk);
            check("feed_a", arr_a, skew_a(t));
            check("feed_w", arr_w, skew_w(t));
            check("start_once", arr_start, 0);
            check("busy_feed", busy, 1);
            next_cycle();
            if (mid_rst && t == 2) begin
                rst       = 1'b0;
                arr_done  = 1'b0;
                arr_ready = 1'b0;
                model_err = 1'b0;
                @(negedge clk);
                check("rst_busy", busy, 0);
                check("rst_arr_a", arr_a, 0);
                check("rst_arr_w", arr_w, 0);
                check("rst_ld_ready", ld_ready, 1);
                check("rst_err", err, 0);
                next_cycle();
                return;
            end
        end
        arr_done  = 1'b0;
        arr_ready = 1'b0;

        if (done_delay < 0) begin
            for (int k = 0; k < TO; k++) begin
                @(negedge clk);
                check("wait_busy", busy, 1);
                check("wait_a_zero", arr_a, 0);
                check("wait_w_zero", arr_w, 0);
                check("wait_err", err, 0);
                next_cycle();
            end
            @(negedge clk);
            check("timeout_err", err, 1);
            check("timeout_busy", busy, 0);
            check("timeout_ld_ready", ld_ready, 1);
            model_err = 1'b1;
            next_cycle();
            return;
        end

        for (int k = 0; k < done_delay; k++) begin
            @(negedge clk);
            check("wait_busy", busy, 1);
            check("wait_a_zero", arr_a, 0);
            check("wait_w_zero", arr_w, 0);
            next_cycle();
        end
        arr_done = 1'b1;
        arr_y    = my[0];
        @(negedge clk);
        check("done_busy", busy, 1);
        check("done_res_valid", res_valid, 0);
        next_cycle();
        for (int i = 1; i < N; i++) begin
            arr_done = noise ? 1'($urandom) : 1'b0;
            arr_y    = my[i];
            @(negedge clk);
            check("cap_res_valid", res_valid, 0);
            check("cap_busy", busy, 1);
            next_cycle();
        end
        arr_y = WD'({$urandom, $urandom});

        r    = 0;
        held = 0;
        cyc  = 0;
        while (r < N && cyc < 200) begin
            arr_done = noise ? 1'($urandom) : 1'b0;
            if (r == bp_row && held < bp_len) res_ready = 1'b0;
            else res_ready = noise ? ($urandom % 3 != 0) : 1'b1;
            @(negedge clk);
            check("res_valid", res_valid, 1);
            check("res_data", res_data, my[r]);
            check("res_last", res_last, r == N - 1);
            check("err_drain", err, 0);
            next_cycle();
            if (res_ready) r++;
            else if (r == bp_row) held++;
            cyc++;
        end
        if (r < N) check("drain_bound", r, N);
        res_ready = 1'b0;
        arr_done  = 1'b0;
        @(negedge clk);
        check("end_busy", busy, 0);
        check("end_res_valid", res_valid, 0);
        check("end_res_data", res_data, 0);
        check("end_ld_ready", ld_ready, 1);
        next_cycle();
    endtask

    initial begin
        rst       = 1'b1;
        ld_valid  = 1'b0;
        ld_data   = '0;
        arr_ready = 1'b0;
        arr_done  = 1'b0;
        arr_y     = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ld_ready", ld_ready, 1);
        check("rst_arr_start", arr_start, 0);
        check("rst_arr_a", arr_a, 0);
        check("rst_arr_w", arr_w, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_last", res_last, 0);
        check("rst_res_data", res_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        next_cycle();

        run_job(1, 0, 3, -1, 0, 0, 0);
        run_job(0, 5, 2, -1, 0, 0, 0);
        run_job(0, 0, 1, 1, 3, 0, 0);
        run_job(0, 0, -1, -1, 0, 0, 0);
        run_job(0, 1, TO - 1, -1, 0, 0, 1);
        run_job(1, 0, 0, -1, 0, 1, 0);
        run_job(1, 0, 4, -1, 0, 0, 0);
        for (int j = 0; j < 12; j++)
            run_job(0, int'($urandom % 4), int'($urandom % TO), -1, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
